// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache controller:
// default geometry and the controller FSM state type.
package cache_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 8;
   localparam int SETS_DEF   = 16;
   localparam int WAYS_DEF   = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_RD,
      MEM_WR,
      RESP
   } state_t;

endpackage

// File: rtl/cache_lru.sv
// Per-set LRU age storage: ages form a permutation per set, 0 = MRU.
// Provides the replacement victim for the currently addressed set.
module cache_lru
   import cache_pkg::*;
#(
   parameter int SETS = SETS_DEF,
   parameter int WAYS = WAYS_DEF,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] set_idx,
   input  logic [WAYS-1:0]  set_valid,
   input  logic             touch,
   input  logic [WAY_W-1:0] touch_way,
   output logic [WAY_W-1:0] victim
);

   logic [WAY_W-1:0] age [SETS][WAYS];
   logic [WAY_W-1:0] touch_age;
   logic             found;

   // Lowest-index invalid way wins; otherwise the oldest way of a full set.
   always_comb begin
      touch_age = age[set_idx][touch_way];
      victim    = '0;
      found     = 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!found && !set_valid[w]) begin
            victim = WAY_W'(w);
            found  = 1'b1;
         end
      end
      if (!found) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            if (age[set_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned s = 0; s < SETS; s++)
            for (int unsigned w = 0; w < WAYS; w++)
               age[s][w] <= WAY_W'(w);
      end else if (touch) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way)
               age[set_idx][w] <= '0;
            else if (age[set_idx][w] < touch_age)
               age[set_idx][w] <= age[set_idx][w] + 1'b1;
         end
      end
   end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// Set-associative, write-through, no-write-allocate cache controller with
// one word per line, LRU replacement and hit/access statistics.
module set_assoc_cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int SETS   = SETS_DEF,
   parameter int WAYS   = WAYS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpuReq,
   output logic              cpuReady,
   input  logic [ADDR_W-1:0] memoryAddress,
   input  logic [DATA_W-1:0] writeValue,
   input  logic              isWrite,
   output logic [DATA_W-1:0] outputdata,
   output logic              respValid,
   input  logic              invalidateAll,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   input  logic              memAck,
   input  logic [DATA_W-1:0] memRdata,
   output logic [31:0]       hitCount,
   output logic [31:0]       accessCount
);

   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int TAG_W = ADDR_W - IDX_W;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;

   logic [WAYS-1:0]   valid    [SETS];
   logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
   logic [DATA_W-1:0] data_mem [SETS][WAYS];

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic [DATA_W-1:0] hit_data;
   logic [WAY_W-1:0]  victim;
   logic [WAY_W-1:0]  touch_way;
   logic              touch;
   logic              fill;
   logic              line_wr;

   assign idx      = addr_q[IDX_W-1:0];
   assign tag      = addr_q[ADDR_W-1:IDX_W];
   assign cpuReady = (state == IDLE) && !invalidateAll;

   always_comb begin
      hit      = 1'b0;
      hit_way  = '0;
      hit_data = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid[idx][w] && (tag_mem[idx][w] == tag)) begin
            hit      = 1'b1;
            hit_way  = WAY_W'(w);
            hit_data = data_mem[idx][w];
         end
      end
   end

   assign fill      = (state == MEM_RD) && memAck;
   assign line_wr   = (state == LOOKUP) && hit && we_q;
   assign touch     = ((state == LOOKUP) && hit) || fill;
   assign touch_way = fill ? victim : hit_way;

   cache_lru #(
      .SETS (SETS),
      .WAYS (WAYS)
   ) u_lru (
      .clk       (clk),
      .rst       (reset),
      .set_idx   (idx),
      .set_valid (valid[idx]),
      .touch     (touch),
      .touch_way (touch_way),
      .victim    (victim)
   );

   // Tag and data storage carry no reset; validity lives in the valid bits.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_mem[idx][victim]  <= tag;
         data_mem[idx][victim] <= memRdata;
      end else if (line_wr) begin
         data_mem[idx][hit_way] <= wdata_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         outputdata  <= '0;
         respValid   <= 1'b0;
         memReq      <= 1'b0;
         memWe       <= 1'b0;
         memAddr     <= '0;
         memWdata    <= '0;
         hitCount    <= '0;
         accessCount <= '0;
         for (int unsigned s = 0; s < SETS; s++) valid[s] <= '0;
      end else begin
         respValid <= 1'b0;
         case (state)
            IDLE: begin
               if (invalidateAll) begin
                  for (int unsigned s = 0; s < SETS; s++) valid[s] <= '0;
               end else if (cpuReq) begin
                  addr_q  <= memoryAddress;
                  wdata_q <= writeValue;
                  we_q    <= isWrite;
                  state   <= LOOKUP;
               end
            end
            LOOKUP: begin
               accessCount <= accessCount + 32'd1;
               if (hit) hitCount <= hitCount + 32'd1;
               if (we_q) begin
                  memReq     <= 1'b1;
                  memWe      <= 1'b1;
                  memAddr    <= addr_q;
                  memWdata   <= wdata_q;
                  outputdata <= wdata_q;
                  state      <= MEM_WR;
               end else if (hit) begin
                  outputdata <= hit_data;
                  respValid  <= 1'b1;
                  state      <= RESP;
               end else begin
                  memReq  <= 1'b1;
                  memWe   <= 1'b0;
                  memAddr <= addr_q;
                  state   <= MEM_RD;
               end
            end
            MEM_RD: begin
               if (memAck) begin
                  valid[idx][victim] <= 1'b1;
                  outputdata         <= memRdata;
                  memReq             <= 1'b0;
                  respValid          <= 1'b1;
                  state              <= RESP;
               end
            end
            MEM_WR: begin
               if (memAck) begin
                  memReq    <= 1'b0;
                  memWe     <= 1'b0;
                  respValid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Self-checking bench for set_assoc_cache_ctrl: directed vector table,
// hand-written invalidate/reset sequences and randomized traffic vs. an LRU model.
module tb_set_assoc_cache_ctrl;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 8;
   localparam int SETS   = 16;
   localparam int WAYS   = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              cpuReq;
   logic              cpuReady;
   logic [ADDR_W-1:0] memoryAddress;
   logic [DATA_W-1:0] writeValue;
   logic              isWrite;
   logic [DATA_W-1:0] outputdata;
   logic              respValid;
   logic              invalidateAll;
   logic              memReq;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWdata;
   logic              memAck = 1'b0;
   logic [DATA_W-1:0] memRdata = '0;
   logic [31:0]       hitCount;
   logic [31:0]       accessCount;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   set_assoc_cache_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .SETS   (SETS),
      .WAYS   (WAYS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cpuReq        (cpuReq),
      .cpuReady      (cpuReady),
      .memoryAddress (memoryAddress),
      .writeValue    (writeValue),
      .isWrite       (isWrite),
      .outputdata    (outputdata),
      .respValid     (respValid),
      .invalidateAll (invalidateAll),
      .memReq        (memReq),
      .memWe         (memWe),
      .memAddr       (memAddr),
      .memWdata      (memWdata),
      .memAck        (memAck),
      .memRdata      (memRdata),
      .hitCount      (hitCount),
      .accessCount   (accessCount)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- backing memory responder ----------------
   logic [7:0] store [logic [31:0]];
   int ack_delay  = 0;
   int ack_wait   = 0;
   int mem_rd_cnt = 0;
   int mem_wr_cnt = 0;

   function automatic logic [7:0] mem_default(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
   endfunction

   always @(negedge clk) begin
      if (memAck) begin
         memAck = 1'b0;
      end else if (memReq) begin
         if (ack_wait >= ack_delay) begin
            memAck   = 1'b1;
            ack_wait = 0;
            if (memWe) begin
               store[memAddr] = memWdata;
               mem_wr_cnt++;
            end else begin
               memRdata = store.exists(memAddr) ? store[memAddr] : mem_default(memAddr);
               mem_rd_cnt++;
            end
         end else begin
            ack_wait++;
         end
      end else begin
         ack_wait = 0;
      end
   end

   // ---------------- reference model: timestamp LRU ----------------
   logic [27:0] m_tag  [SETS][WAYS];
   logic [7:0]  m_data [SETS][WAYS];
   bit          m_vld  [SETS][WAYS];
   int          m_use  [SETS][WAYS];
   logic [7:0]  m_mem  [logic [31:0]];
   int          m_now  = 0;
   int          m_hits = 0;
   int          m_acc  = 0;

   task automatic model_invalidate();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) m_vld[s][w] = 1'b0;
   endtask

   task automatic model_access(input logic [31:0] a, input logic [7:0] wd, input bit we,
                               output logic [7:0] d, output bit h);
      int s;
      int way;
      logic [27:0] t;
      s   = int'(a[3:0]);
      t   = a[31:4];
      way = -1;
      m_acc++;
      m_now++;
      for (int w = 0; w < WAYS; w++)
         if (m_vld[s][w] && m_tag[s][w] == t) way = w;
      h = (way >= 0);
      if (h) m_hits++;
      if (we) begin
         m_mem[a] = wd;
         d = wd;
         if (h) begin
            m_data[s][way] = wd;
            m_use[s][way]  = m_now;
         end
      end else if (h) begin
         d = m_data[s][way];
         m_use[s][way] = m_now;
      end else begin
         d = m_mem.exists(a) ? m_mem[a] : mem_default(a);
         for (int w = 0; w < WAYS; w++)
            if (!m_vld[s][w] && way < 0) way = w;
         if (way < 0) begin
            way = 0;
            for (int w = 1; w < WAYS; w++)
               if (m_use[s][w] < m_use[s][way]) way = w;
         end
         m_vld[s][way]  = 1'b1;
         m_tag[s][way]  = t;
         m_data[s][way] = d;
         m_use[s][way]  = m_now;
      end
   endtask

   // ---------------- transaction driver (called at a negedge, DUT idle) ----------------
   task automatic do_txn(input logic [31:0] a, input logic [7:0] wd, input bit we, input int dly,
                         output logic [7:0] data, output bit hit, output int lat,
                         output int nrd, output int nwr);
      logic [31:0] h0;
      int rd0;
      int wr0;
      ack_delay     = dly;
      h0            = hitCount;
      rd0           = mem_rd_cnt;
      wr0           = mem_wr_cnt;
      cpuReq        = 1'b1;
      memoryAddress = a;
      writeValue    = wd;
      isWrite       = we;
      #1 check("cpu_ready", cpuReady, 1);
      @(posedge clk);
      #1 cpuReq = 1'b0;
      lat = 1;
      while (!respValid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("resp_seen", respValid, 1);
      data = outputdata;
      hit  = ((hitCount - h0) == 32'd1);
      nrd  = mem_rd_cnt - rd0;
      nwr  = mem_wr_cnt - wr0;
      @(posedge clk);
      #1 check("resp_one_cycle", respValid, 0);
      @(negedge clk);
   endtask

   task automatic run_checked(input logic [31:0] a, input logic [7:0] wd, input bit we, input int dly);
      logic [7:0] ed;
      logic [7:0] d;
      bit eh;
      bit h;
      int lat;
      int nrd;
      int nwr;
      model_access(a, wd, we, ed, eh);
      do_txn(a, wd, we, dly, d, h, lat, nrd, nwr);
      check("m_data", d, ed);
      check("m_hit", h, eh);
      check("m_latency", lat, (eh && !we) ? 2 : 3 + dly);
      check("m_mem_rd", nrd, (!we && !eh) ? 1 : 0);
      check("m_mem_wr", nwr, we ? 1 : 0);
      check("m_hitCount", hitCount, m_hits);
      check("m_accessCount", accessCount, m_acc);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  wdata;
      bit          we;
      bit          exp_hit;
      logic [7:0]  exp_data;
      int          exp_hits;
      int          exp_acc;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic [7:0] ed;
      bit h;
      bit eh;
      int lat;
      int nrd;
      int nwr;
      logic [31:0] acc0;
      logic [31:0] a;

      reset         = 1'b1;
      cpuReq        = 1'b0;
      memoryAddress = '0;
      writeValue    = '0;
      isWrite       = 1'b0;
      invalidateAll = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outputdata", outputdata, 0);
      check("rst_respValid", respValid, 0);
      check("rst_memReq", memReq, 0);
      check("rst_memWe", memWe, 0);
      check("rst_memAddr", memAddr, 0);
      check("rst_memWdata", memWdata, 0);
      check("rst_hitCount", hitCount, 0);
      check("rst_accessCount", accessCount, 0);
      check("rst_cpuReady", cpuReady, 1);
      reset = 1'b0;
      @(negedge clk);
      model_invalidate();

      // Directed vectors: four fills of set 1, LRU hits/evictions, write-through behaviour.
      vecs.push_back('{32'h02001f81, 8'h00, 1'b0, 1'b0, mem_default(32'h02001f81), 0, 1});
      vecs.push_back('{32'h02001f71, 8'h00, 1'b0, 1'b0, mem_default(32'h02001f71), 0, 2});
      vecs.push_back('{32'h02001f41, 8'h00, 1'b0, 1'b0, mem_default(32'h02001f41), 0, 3});
      vecs.push_back('{32'h02001f51, 8'h00, 1'b0, 1'b0, mem_default(32'h02001f51), 0, 4});
      vecs.push_back('{32'h02001f71, 8'h00, 1'b0, 1'b1, mem_default(32'h02001f71), 1, 5});
      vecs.push_back('{32'h02001f41, 8'h00, 1'b0, 1'b1, mem_default(32'h02001f41), 2, 6});
      vecs.push_back('{32'h02001f61, 8'h00, 1'b0, 1'b0, mem_default(32'h02001f61), 2, 7});
      vecs.push_back('{32'h02001f81, 8'h00, 1'b0, 1'b0, mem_default(32'h02001f81), 2, 8});
      vecs.push_back('{32'h02001f71, 8'h55, 1'b1, 1'b1, 8'h55, 3, 9});
      vecs.push_back('{32'h02001f71, 8'h00, 1'b0, 1'b1, 8'h55, 4, 10});
      vecs.push_back('{32'h03000002, 8'h77, 1'b1, 1'b0, 8'h77, 4, 11});
      vecs.push_back('{32'h03000002, 8'h00, 1'b0, 1'b0, 8'h77, 4, 12});
      vecs.push_back('{32'h02001f51, 8'h00, 1'b0, 1'b0, mem_default(32'h02001f51), 4, 13});

      foreach (vecs[i]) begin
         model_access(vecs[i].addr, vecs[i].wdata, vecs[i].we, ed, eh);
         do_txn(vecs[i].addr, vecs[i].wdata, vecs[i].we, 0, d, h, lat, nrd, nwr);
         check("vec_data", d, vecs[i].exp_data);
         check("vec_hit", h, vecs[i].exp_hit);
         check("vec_latency", lat, (vecs[i].exp_hit && !vecs[i].we) ? 2 : 3);
         check("vec_mem_rd", nrd, (!vecs[i].we && !vecs[i].exp_hit) ? 1 : 0);
         check("vec_mem_wr", nwr, vecs[i].we ? 1 : 0);
         check("vec_hitCount", hitCount, vecs[i].exp_hits);
         check("vec_accessCount", accessCount, vecs[i].exp_acc);
      end

      // invalidateAll beats a simultaneous request; nothing is accepted.
      acc0          = accessCount;
      invalidateAll = 1'b1;
      cpuReq        = 1'b1;
      memoryAddress = 32'h02001f71;
      isWrite       = 1'b0;
      #1 check("inv_cpuReady", cpuReady, 0);
      @(negedge clk);
      invalidateAll = 1'b0;
      cpuReq        = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("inv_no_lookup", accessCount, acc0);
      check("inv_no_resp", respValid, 0);
      check("inv_no_memReq", memReq, 0);
      model_invalidate();
      run_checked(32'h02001f71, 8'h00, 1'b0, 0);
      check("inv_then_miss", hitCount, 4);

      // Reset while waiting for memAck in a read miss.
      ack_delay     = 100000;
      cpuReq        = 1'b1;
      memoryAddress = 32'h02001f41;
      isWrite       = 1'b0;
      @(posedge clk);
      #1 cpuReq = 1'b0;
      lat = 0;
      while (!memReq && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("rstmid_memReq_up", memReq, 1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rstmid_memReq", memReq, 0);
      check("rstmid_memWe", memWe, 0);
      check("rstmid_memAddr", memAddr, 0);
      check("rstmid_hitCount", hitCount, 0);
      check("rstmid_accessCount", accessCount, 0);
      check("rstmid_outputdata", outputdata, 0);
      @(negedge clk);
      reset     = 1'b0;
      ack_delay = 0;
      @(negedge clk);
      model_invalidate();
      m_hits = 0;
      m_acc  = 0;
      run_checked(32'h02001f41, 8'h00, 1'b0, 0);
      check("rstmid_then_miss", mem_rd_cnt > 0 && hitCount == 0, 1);

      // Randomized traffic over a small tag pool so sets overflow and hit.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            invalidateAll = 1'b1;
            @(negedge clk);
            invalidateAll = 1'b0;
            model_invalidate();
         end
         a = 32'h4000_0000 | (32'($urandom_range(0, 5)) << 8) | 32'($urandom_range(0, 3));
         run_checked(a, 8'($urandom), ($urandom_range(0, 9) < 3), int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/set_assoc_cache_ctrl.md
SET_ASSOC_CACHE_CTRL -- requirements
Module: set_assoc_cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte address width.
REQ-002 SHALL have parameter DATA_W, default 8: data word width; one word per cache line.
REQ-003 SHALL have parameter SETS, default 16: set count, power of two, at least 2.
REQ-004 SHALL have parameter WAYS, default 4: associativity, power of two, at least 2.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port cpuReq, input, 1: request valid.
REQ-008 SHALL have port cpuReady, output, 1: request accepted when cpuReq and cpuReady are both high.
REQ-009 SHALL have ports memoryAddress (input, ADDR_W), writeValue (input, DATA_W) and isWrite (input, 1): request fields.
REQ-010 SHALL have ports outputdata (output, DATA_W) and respValid (output, 1): response data and a one-cycle completion strobe.
REQ-011 SHALL have port invalidateAll, input, 1: clears all valid bits.
REQ-012 SHALL have ports memReq, memWe (output, 1), memAddr (output, ADDR_W), memWdata (output, DATA_W), memAck (input, 1) and memRdata (input, DATA_W): backing-memory handshake.
REQ-013 SHALL have ports hitCount and accessCount, output, 32: statistics.

Function
REQ-014 SHALL split the address as index = memoryAddress[log2(SETS)-1:0] and tag = the remaining upper bits.
REQ-015 SHALL implement FSM states IDLE, LOOKUP, MEM_RD, MEM_WR and RESP.
REQ-016 SHALL drive cpuReady = (state == IDLE) && !invalidateAll, combinationally.
REQ-017 SHALL, in IDLE, register address, writeValue and isWrite when a request is accepted, then go to LOOKUP.
REQ-018 SHALL, in LOOKUP (one cycle), increment accessCount and compare the tag against all valid ways of the set in parallel.
REQ-019 SHALL, on a read hit, increment hitCount, load outputdata from the hit way, update LRU and go to RESP.
REQ-020 SHALL, on a read miss, go to MEM_RD.
REQ-021 SHALL, on a write hit, increment hitCount, update the line and LRU, and go to MEM_WR (write-through).
REQ-022 SHALL, on a write miss, go to MEM_WR with no allocation and no LRU change.
REQ-023 SHALL, in MEM_RD, hold memReq=1, memWe=0 and memAddr=captured address until memAck is sampled high.
REQ-024 SHALL, on that memAck, fill the victim way (valid, tag, data), load memRdata into outputdata, mark the victim MRU and go to RESP.
REQ-025 SHALL, in MEM_WR, hold memReq=1, memWe=1, memAddr and memWdata=captured values until memAck, then go to RESP; outputdata = writeValue.
REQ-026 SHALL select as victim the lowest-index invalid way, or the way with age WAYS-1 if the set is full.
REQ-027 SHALL keep per-way age counters of log2(WAYS) bits per set; on a touch of way w with age a, every way with age < a increments and w becomes 0; ages stay a permutation.
REQ-028 SHALL assert respValid for exactly one cycle in RESP, then return to IDLE.
REQ-029 SHALL give read-hit latency of exactly 2 cycles from acceptance to respValid; miss latency is 2 + memAck wait + 1.
REQ-030 SHALL, on invalidateAll in IDLE, clear all valid bits in one cycle; the assertion takes priority over a simultaneous cpuReq, which is not accepted.
REQ-031 SHALL ignore invalidateAll outside IDLE.
REQ-032 SHALL let both statistic counters wrap modulo 2^32.
REQ-033 SHALL hold memReq low except in MEM_RD and MEM_WR.

Reset
REQ-034 SHALL, on reset assertion at any time including mid-transaction, immediately force: state=IDLE, all valid bits=0, ages of way i = i, outputdata=0, respValid=0, memReq=0, memWe=0, memAddr=0, memWdata=0, hitCount=0, accessCount=0.
REQ-035 SHALL NOT reset tag or data arrays.

Structure
REQ-036 SHALL place the FSM state enum and the default parameter values in shared package cache_pkg.
REQ-037 SHALL implement per-set age storage, update and victim selection in sub-module cache_lru.
REQ-038 SHALL use flops for the tag/data/valid arrays (no SRAM macro).

Verification
REQ-039 SHALL cover, with defaults and memAck one cycle after memReq: reads 0x02001f81, 71, 41, 51, 71, 41 -> first four miss and fill ways 0-3, last two hit; hitCount=2, accessCount=6.
REQ-040 SHALL cover continuing with read 0x02001f61 then 0x02001f81 -> 61 evicts 81 (LRU), 81 evicts 51; hitCount=2, accessCount=8.
REQ-041 SHALL cover write 0x55 to 0x02001f71 (resident) -> memWe transaction issued, a following read returns 0x55 as a hit with no memReq.
REQ-042 SHALL cover write to non-resident 0x0300_0002 then a read of the same address -> the read misses.
REQ-043 SHALL cover invalidateAll and cpuReq high together in IDLE -> cpuReady=0, no LOOKUP; the next read of a previously resident address misses.
REQ-044 SHALL cover reset asserted during MEM_RD while memAck is low -> memReq drops asynchronously, counters=0, a subsequent read misses.
